// File: rtl/lcd_text_buffer_if.sv
// Bus bundle between the game/control logic, the LCD driver and the text buffer.
// The buffer uses the slave modport; the master side issues writes, reads and acks.
interface lcd_text_buffer_if #(
   parameter int COLS = 16
);
   localparam int CW = $clog2(COLS);

   logic          wr_en;
   logic [7:0]    wr_char;
   logic          set_cur;
   logic          cur_row;
   logic [CW-1:0] cur_col;
   logic          clr;
   logic          busy;
   logic          rd_row;
   logic [CW-1:0] rd_col;
   logic [7:0]    rd_data;
   logic          dirty;
   logic          refresh_ack;
   logic          cursor_row;
   logic [CW-1:0] cursor_col;

   modport master (
      output wr_en, wr_char, set_cur, cur_row, cur_col, clr, rd_row, rd_col, refresh_ack,
      input  busy, rd_data, dirty, cursor_row, cursor_col
   );

   modport slave (
      input  wr_en, wr_char, set_cur, cur_row, cur_col, clr, rd_row, rd_col, refresh_ack,
      output busy, rd_data, dirty, cursor_row, cursor_col
   );
endinterface

// File: rtl/lcd_text_buffer.sv
// Two-row character frame buffer feeding a text-LCD driver: cursor write port,
// registered (row, col) read port, self-clearing after reset, dirty/ack refresh flag.
module lcd_text_buffer #(
   parameter int         COLS      = 16,
   parameter logic [7:0] FILL_CHAR = 8'h20
) (
   input logic               clk,
   input logic               resetn,
   lcd_text_buffer_if.slave  bus
);
   localparam int CW    = $clog2(COLS);
   localparam int AW    = CW + 1;
   localparam int DEPTH = 2 * COLS;

   typedef logic [AW-1:0] addr_t;
   typedef enum logic {CLEAR, IDLE} state_t;

   localparam addr_t LAST = addr_t'(DEPTH - 1);

   state_t     state, state_next;
   addr_t      idx, idx_next;
   addr_t      cursor, cursor_next;
   addr_t      wr_addr, cur_target, rd_addr;
   logic       we;
   logic [7:0] wr_data;
   logic       set_dirty;
   logic       dirty;
   logic [7:0] rd_data;
   logic [7:0] mem [DEPTH];

   // Cursor is held as the linear {row, col} index, so +1 gives the row-wrap order for free.
   assign cur_target = {bus.cur_row, bus.cur_col};
   assign rd_addr    = {bus.rd_row, bus.rd_col};

   // NOTE: combinational logic uses blocking '=' and gives every output a default first, so no latch is inferred.
   always_comb begin
      state_next  = state;
      idx_next    = idx;
      cursor_next = cursor;
      we          = 1'b0;
      wr_addr     = cursor;
      wr_data     = bus.wr_char;
      set_dirty   = 1'b0;
      unique case (state)
         CLEAR: begin
            we       = 1'b1;
            wr_addr  = idx;
            wr_data  = FILL_CHAR;
            idx_next = idx + addr_t'(1);
            if (idx == LAST) begin
               state_next  = IDLE;
               set_dirty   = 1'b1;
               cursor_next = '0;
            end
         end
         IDLE: begin
            if (bus.clr) begin
               state_next = CLEAR;
               idx_next   = '0;
            end else if (bus.set_cur && bus.wr_en) begin
               we          = 1'b1;
               wr_addr     = cur_target;
               cursor_next = cur_target + addr_t'(1);
               set_dirty   = 1'b1;
            end else if (bus.set_cur) begin
               cursor_next = cur_target;
            end else if (bus.wr_en) begin
               we          = 1'b1;
               cursor_next = cursor + addr_t'(1);
               set_dirty   = 1'b1;
            end
         end
         default: state_next = CLEAR;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking '<=' only.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= CLEAR;
         idx     <= '0;
         cursor  <= '0;
         dirty   <= 1'b0;
         rd_data <= FILL_CHAR;
      end else begin
         state   <= state_next;
         idx     <= idx_next;
         cursor  <= cursor_next;
         dirty   <= set_dirty | (dirty & ~bus.refresh_ack);
         rd_data <= mem[rd_addr];
      end
   end

   // NOTE: the array itself has no reset; the CLEAR sweep after every reset initialises it.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign bus.busy       = (state == CLEAR);
   assign bus.dirty      = dirty;
   assign bus.rd_data    = rd_data;
   assign bus.cursor_row = cursor[AW-1];
   assign bus.cursor_col = cursor[CW-1:0];
endmodule

// File: tb/tb_lcd_text_buffer.sv
// Scoreboard bench for lcd_text_buffer: the driver queues expected outputs with a
// due cycle, and a negedge monitor compares them when that cycle arrives.
module tb_lcd_text_buffer;
   localparam int COLS = 16;

   typedef enum int {S_BUSY, S_DIRTY, S_RD, S_CUR} sig_e;
   typedef struct {
      int         due;
      sig_e       sig;
      logic [7:0] exp;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   lcd_text_buffer_if #(.COLS(COLS)) bus();

   lcd_text_buffer #(.COLS(COLS), .FILL_CHAR(8'h20)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] actual(input sig_e s);
      case (s)
         S_BUSY:  return {7'b0, bus.busy};
         S_DIRTY: return {7'b0, bus.dirty};
         S_RD:    return bus.rd_data;
         default: return {3'b0, bus.cursor_row, bus.cursor_col};
      endcase
   endfunction

   // Monitor: compare every scoreboard entry that falls due on this cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            check(sb[i].name, actual(sb[i].sig), sb[i].exp);
            sb.delete(i);
         end else if (sb[i].due < cyc) begin
            errors++;
            $display("FAIL %s overdue: due cycle %0d, now %0d", sb[i].name, sb[i].due, cyc);
            sb.delete(i);
         end
      end
   end

   task automatic push_exp(input int lag, input sig_e sig, input logic [7:0] exp, input string name);
      exp_t e;
      e.due  = cyc + lag;
      e.sig  = sig;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic quiet();
      bus.wr_en       = 1'b0;
      bus.wr_char     = 8'h00;
      bus.set_cur     = 1'b0;
      bus.cur_row     = 1'b0;
      bus.cur_col     = '0;
      bus.clr         = 1'b0;
      bus.refresh_ack = 1'b0;
   endtask

   task automatic rd_check(input logic row, input int col, input logic [7:0] exp, input string name);
      bus.rd_row = row;
      bus.rd_col = 4'(col);
      push_exp(1, S_RD, exp, name);
      tick();
   endtask

   task automatic set_cursor(input logic row, input int col, input logic [7:0] exp_cur);
      bus.set_cur = 1'b1;
      bus.cur_row = row;
      bus.cur_col = 4'(col);
      push_exp(1, S_CUR, exp_cur, "set_cur");
      tick();
      bus.set_cur = 1'b0;
   endtask

   task automatic wr(input logic [7:0] ch, input logic [7:0] exp_cur);
      bus.wr_en   = 1'b1;
      bus.wr_char = ch;
      push_exp(1, S_CUR, exp_cur, "wr_cursor");
      tick();
      bus.wr_en = 1'b0;
   endtask

   initial begin
      quiet();
      bus.rd_row = 1'b0;
      bus.rd_col = '0;
      resetn     = 1'b0;
      tick();
      tick();
      push_exp(1, S_BUSY,  8'h01, "rst_busy");
      push_exp(1, S_DIRTY, 8'h00, "rst_dirty");
      push_exp(1, S_RD,    8'h20, "rst_rd_data");
      push_exp(1, S_CUR,   8'h00, "rst_cursor");
      tick();

      // Release: 32 CLEAR cycles, then IDLE with dirty set.
      resetn = 1'b1;
      push_exp(1,  S_BUSY,  8'h01, "clear_busy_first");
      push_exp(31, S_BUSY,  8'h01, "clear_busy_last");
      push_exp(31, S_DIRTY, 8'h00, "clear_dirty_pending");
      push_exp(32, S_BUSY,  8'h00, "clear_busy_done");
      push_exp(32, S_DIRTY, 8'h01, "clear_dirty_set");
      push_exp(32, S_CUR,   8'h00, "clear_cursor");
      repeat (32) tick();
      rd_check(1'b0, 0,  8'h20, "fill_0_0");
      rd_check(1'b1, 15, 8'h20, "fill_1_15");

      // Row-crossing writes.
      set_cursor(1'b0, 14, 8'd14);
      wr(8'h57, 8'd15);
      wr(8'h69, 8'd16);
      wr(8'h6E, 8'd17);
      rd_check(1'b0, 14, 8'h57, "mem_0_14");
      rd_check(1'b0, 15, 8'h69, "mem_0_15");
      rd_check(1'b1, 0,  8'h6E, "mem_1_0");

      // Full wrap from the last cell back to (0,0).
      set_cursor(1'b1, 15, 8'd31);
      wr(8'h23, 8'd0);
      wr(8'h21, 8'd1);
      rd_check(1'b1, 15, 8'h23, "mem_1_15");
      rd_check(1'b0, 0,  8'h21, "mem_0_0_wrap");

      // Dirty handshake.
      bus.refresh_ack = 1'b1;
      push_exp(1, S_DIRTY, 8'h00, "ack_clears");
      tick();
      bus.wr_en   = 1'b1;
      bus.wr_char = 8'h78;
      push_exp(1, S_DIRTY, 8'h01, "set_beats_ack");
      push_exp(1, S_CUR,   8'd2,  "ack_wr_cursor");
      tick();
      bus.wr_en = 1'b0;
      push_exp(1, S_DIRTY, 8'h00, "ack_alone");
      tick();
      push_exp(1, S_DIRTY, 8'h00, "ack_when_clean");
      tick();
      bus.refresh_ack = 1'b0;
      rd_check(1'b0, 1, 8'h78, "mem_0_1");

      // Read-before-write on the same address, written through set_cur+wr_en.
      bus.set_cur = 1'b1;
      bus.cur_row = 1'b0;
      bus.cur_col = 4'd3;
      bus.wr_en   = 1'b1;
      bus.wr_char = 8'h41;
      bus.rd_row  = 1'b0;
      bus.rd_col  = 4'd3;
      push_exp(1, S_RD,  8'h20, "rbw_old");
      push_exp(1, S_CUR, 8'd4,  "setwr_cursor");
      tick();
      quiet();
      push_exp(1, S_RD,    8'h41, "rbw_new");
      push_exp(1, S_DIRTY, 8'h01, "setwr_dirty");
      tick();

      // clr with a same-cycle write (dropped) and ack.
      bus.clr         = 1'b1;
      bus.wr_en       = 1'b1;
      bus.wr_char     = 8'h58;
      bus.refresh_ack = 1'b1;
      push_exp(1,  S_BUSY,  8'h01, "clr_busy");
      push_exp(1,  S_CUR,   8'd4,  "clr_drops_write");
      push_exp(1,  S_DIRTY, 8'h00, "clr_ack");
      push_exp(32, S_BUSY,  8'h01, "clr_busy_last");
      push_exp(32, S_DIRTY, 8'h00, "clr_dirty_pending");
      push_exp(33, S_BUSY,  8'h00, "clr_busy_done");
      push_exp(33, S_DIRTY, 8'h01, "clr_dirty_set");
      push_exp(33, S_CUR,   8'd0,  "clr_cursor");
      tick();
      quiet();
      repeat (4) tick();
      bus.wr_en   = 1'b1;
      bus.wr_char = 8'h5A;
      bus.set_cur = 1'b1;
      bus.cur_row = 1'b1;
      bus.cur_col = 4'd7;
      bus.clr     = 1'b1;
      push_exp(1, S_CUR, 8'd4, "busy_ignores_inputs");
      tick();
      quiet();
      repeat (27) tick();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < COLS; c++)
            rd_check(r[0], c, 8'h20, $sformatf("cleared_%0d_%0d", r, c));

      // Reset in the middle of a clear restarts the full sweep.
      bus.clr = 1'b1;
      push_exp(1, S_BUSY, 8'h01, "clr2_busy");
      tick();
      quiet();
      repeat (9) tick();
      resetn = 1'b0;
      push_exp(1, S_BUSY,  8'h01, "midrst_busy");
      push_exp(1, S_DIRTY, 8'h00, "midrst_dirty");
      push_exp(1, S_CUR,   8'd0,  "midrst_cursor");
      tick();
      resetn = 1'b1;
      push_exp(1,  S_BUSY,  8'h01, "restart_busy_first");
      push_exp(31, S_BUSY,  8'h01, "restart_busy_last");
      push_exp(32, S_BUSY,  8'h00, "restart_busy_done");
      push_exp(32, S_DIRTY, 8'h01, "restart_dirty_set");
      repeat (32) tick();

      begin
         int guard = 0;
         while (sb.size() != 0 && guard < 100) begin
            tick();
            guard++;
         end
         if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
            errors += sb.size();
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lcd_text_buffer.md
Name: lcd_text_buffer

Overview:
- 2-row character frame buffer that sits directly upstream of the text-LCD driver.
- Game/control logic writes ASCII characters through a cursor-based write port.
- The LCD driver reads characters by (row, col) address while sequencing its line1/line2 output.
- A dirty/ack handshake tells the driver when a display refresh is needed.

Parameters:
- COLS, 16: characters per row. Power of two; column index width CW = log2(COLS). Row count is fixed at 2.
- FILL_CHAR, 8'h20: character written by clear (ASCII space).

Ports:
- clk  in  1  system clock, all logic on the rising edge
- resetn  in  1  asynchronous, active-low reset
- wr_en  in  1  write wr_char at the cursor position, then advance the cursor
- wr_char  in  8  ASCII character to write
- set_cur  in  1  load the cursor from cur_row/cur_col
- cur_row  in  1  cursor row to load
- cur_col  in  CW  cursor column to load
- clr  in  1  start a clear of the whole buffer
- busy  out  1  clear in progress; wr_en, set_cur and clr are ignored while high
- rd_row  in  1  read row (driven by the LCD driver)
- rd_col  in  CW  read column
- rd_data  out  8  registered read data
- dirty  out  1  buffer content has changed since the last refresh_ack
- refresh_ack  in  1  single-cycle pulse from the driver at the start of a refresh
- cursor_row  out  1  current cursor row
- cursor_col  out  CW  current cursor column

Behaviour:
- Storage: 2*COLS x 8-bit array. Linear index = {row, col}, width CW+1.
- Reset (resetn low, asynchronous):
  - busy=1, dirty=0, rd_data=FILL_CHAR, cursor_row=0, cursor_col=0.
  - FSM goes to CLEAR with clear index 0.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle, mem[idx] <= FILL_CHAR and idx increments.
  - After writing idx = 2*COLS-1 (cycle 2*COLS), go to IDLE. On that transition: busy=0, dirty=1, cursor=(0,0).
  - From the end of reset, the first IDLE cycle is cycle 2*COLS+1, i.e. 32 CLEAR cycles at the default COLS.
  - clr, set_cur and wr_en are all ignored.
  - resetn low mid-clear restarts the clear from idx 0.
- IDLE, same-cycle priority:
  - clr: go to CLEAR with idx 0, busy=1 on the next cycle. set_cur and wr_en in the same cycle are dropped.
  - set_cur without wr_en: cursor <= (cur_row, cur_col).
  - set_cur with wr_en: the character is written at (cur_row, cur_col), then cursor <= that position + 1.
  - wr_en alone: mem[cursor] <= wr_char, then cursor advances.
- Cursor advance:
  - col+1 within a row.
  - col COLS-1 → col 0 of the other row.
  - (1, COLS-1) wraps to (0, 0).
- dirty:
  - Set by every accepted write and by clear completion.
  - Cleared by refresh_ack.
  - If set and refresh_ack occur in the same cycle, dirty stays 1 (set wins).
  - refresh_ack while dirty=0 has no effect.
- Read port:
  - rd_data <= mem[{rd_row, rd_col}] every cycle, in all states. Latency is 1 clock.
  - Read-before-write: a same-cycle write to the read address returns the old value; the new value appears on the following read.
- Cursor outputs are registered and reflect the cursor after the current edge.
- No combinational path from any input to any output.

Test Plan:
- Reset then release:
  - busy=1 for 32 cycles, then 0; dirty=1; cursor=(0,0).
  - Read of (0,0) and (1,15) returns 8'h20.
- set_cur (0,14), then write 'W' (8'h57), 'i' (8'h69), 'n' (8'h6E):
  - mem(0,14)=8'h57, mem(0,15)=8'h69, mem(1,0)=8'h6E.
  - Final cursor=(1,1).
- set_cur (1,15), then write '#' (8'h23) then '!' (8'h21):
  - (1,15)=8'h23, (0,0)=8'h21; cursor=(0,1) after wrap.
- Dirty handshake:
  - refresh_ack pulse → dirty=0.
  - Write with refresh_ack in the same cycle → dirty stays 1.
  - refresh_ack alone → dirty=0.
  - refresh_ack with dirty=0 → dirty stays 0.
- Read latency and read-before-write:
  - rd addr (0,3) with a same-cycle wr_en of 8'h41 at (0,3) → next-cycle rd_data = old value 8'h20.
  - The read one cycle later returns 8'h41.
- clr in IDLE with wr_en in the same cycle:
  - Write dropped; busy=1 for 32 cycles; all cells 8'h20.
  - wr_en during busy leaves the buffer unchanged.
  - resetn pulsed at clear cycle 10 → busy persists a fresh 32 cycles.
